cook_timer_ctrl: RTL and testbench
==================================

# cook_timer_ctrl

Front-panel control FSM that consumes the one-cycle debounced button pulses from the button stage and runs a cook/exposure countdown timer with a door interlock. It holds the set time as minutes:seconds, counts it down once per second while running, drives the heater enable and a timed completion alarm, and presents minutes/seconds and state to the display stage.

## Interface

Parameters:
- CLK_HZ, 100_000_000, clock cycles per 1 s tick (≥2)
- STEP_SEC, 10, seconds added/removed per Up/Down press (1..59)
- ALARM_SEC, 3, seconds alarm stays high in DONE (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rise_button  in  5  one-cycle press pulses: [0] Up, [1] Door, [2] Start, [3] Cancel, [4] Down
- min_out  out  7  remaining minutes, binary 0..99
- sec_out  out  6  remaining seconds, binary 0..59
- state  out  3  IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4
- heater_on  out  1  high only in RUN
- door_open  out  1  door flag, toggled by Door
- alarm  out  1  high throughout DONE
- done_pulse  out  1  one-cycle pulse on RUN→DONE

## Operation

- All outputs registered; reset: state IDLE, min/sec 0, heater_on/door_open/alarm/done_pulse 0, prescaler 0.
- One event per cycle. Button priority: Cancel > Door > Start > Up > Down; lower bits in the same cycle are dropped.
- Door toggles door_open in every state. Opening in RUN → PAUSE.
- IDLE: Up → SET with time = STEP_SEC. Down/Start/Cancel ignored.
- SET: Up adds STEP_SEC; Down subtracts; Start → RUN only if time≠0 and door closed; Cancel → IDLE, time cleared.
- RUN: tick decrements 1 s; Up adds STEP_SEC; Down and Start ignored; Cancel → PAUSE.
- PAUSE: Up/Down adjust as in SET; Start → RUN (same guard); Cancel → IDLE, time cleared.
- DONE: time 00:00, alarm=1; any rise_button bit → IDLE (Door also toggles); after ALARM_SEC ticks → IDLE.
- Up arithmetic: sec+STEP ≥60 → sec-=60-STEP, min+1. Result >99:59 saturates to 99:59.
- Down arithmetic: borrow from min when sec<STEP. Total <STEP → 00:00; if result 00:00 in SET/PAUSE → IDLE.
- Decrement: sec=0 → sec=59, min-1. Decrement to 00:00 → DONE, done_pulse=1 for that cycle.

## Timing

- Button response: outputs reflect a pulse at the clock edge that samples it (1-cycle latency).
- Prescaler counts 0..CLK_HZ-1 in RUN and DONE, cleared in every other state and on every state entry. The tick is the cycle it equals CLK_HZ-1. The first decrement lands exactly CLK_HZ cycles after the edge that enters RUN.
- Tick and button in the same RUN cycle: Cancel/Door win, with no decrement. Otherwise the tick wins and Up is dropped.
- heater_on asserts the cycle state becomes RUN and deasserts the cycle it leaves.
- The alarm countdown uses the same tick; DONE lasts ALARM_SEC×CLK_HZ cycles if no button is pressed.
- Reset asserted mid-run: immediate return to reset values; no done_pulse.

## Test plan

- CLK_HZ=10. Reset, Up×3 → SET, 00:30; Start → RUN, heater_on=1; the first decrement lands 10 cycles later (00:29).
- Set 00:02 and run → done_pulse once at 00:00, state DONE, alarm=1 for 3×10 cycles, then IDLE with alarm=0.
- Door during RUN at 00:15 → PAUSE, heater_on=0, door_open=1. Start is ignored while the door is open. Door again, then Start → RUN resumes from 00:15.
- Up from 99:55 → 99:59 (saturate). Down from 00:05 → 00:00 and IDLE. Up at 00:55 → 01:05.
- Cancel+Start+Up in the same cycle from SET → IDLE with time cleared. Cancel in RUN → PAUSE; Cancel again → IDLE.
- Reset asserted while in RUN at 00:10 → all outputs 0, state IDLE, on the reset edge without waiting for clk.

Source files
------------

// File: rtl/cook_timer_ctrl.sv
// Cook / exposure countdown timer front-panel controller.
// Consumes one-cycle button pulses, keeps the set time as minutes:seconds,
// counts down once per second while running, drives heater and alarm,
// and handles the door interlock.
module cook_timer_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int STEP_SEC  = 10,
    parameter int ALARM_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rise_button,
    output logic [6:0] min_out,
    output logic [5:0] sec_out,
    output logic [2:0] state,
    output logic       heater_on,
    output logic       door_open,
    output logic       alarm,
    output logic       done_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Prescaler spans 0..CLK_HZ-1; alarm counter spans 0..ALARM_SEC-1.
    localparam int PW  = $clog2(CLK_HZ);
    localparam int ACW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    localparam logic [PW-1:0]  PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_SEC - 1);
    localparam logic [ACW-1:0] ALARM_ONE  = ACW'(1);
    localparam logic [6:0]     STEP7      = 7'(STEP_SEC);
    localparam logic [5:0]     STEP6      = 6'(STEP_SEC);

    state_t         state_reg, state_next;
    logic [6:0]     min_reg, min_next;
    logic [5:0]     sec_reg, sec_next;
    logic           door_reg, door_next;
    logic           done_reg, done_next;
    logic           heater_reg;
    logic           alarm_reg;
    logic [PW-1:0]  presc_reg, presc_next;
    logic [ACW-1:0] alarm_cnt_reg, alarm_cnt_next;

    logic ev_cancel, ev_door, ev_start, ev_up, ev_down;
    logic tick;
    logic time_nz;

    logic [6:0] up_sum;
    logic [6:0] up_min, dn_min, dec_min;
    logic [5:0] up_sec, dn_sec, dec_sec;
    logic       dn_zero, dec_zero;

    // Single winning event per cycle: Cancel > Door > Start > Up > Down.
    always_comb begin
        ev_cancel = rise_button[3];
        ev_door   = rise_button[1] & ~rise_button[3];
        ev_start  = rise_button[2] & ~rise_button[3] & ~rise_button[1];
        ev_up     = rise_button[0] & ~(|rise_button[3:1]);
        ev_down   = rise_button[4] & ~(|rise_button[3:0]);
    end

    // One-second tick exists only while the prescaler is live.
    assign tick    = ((state_reg == ST_RUN) || (state_reg == ST_DONE)) && (presc_reg == PRESC_MAX);
    assign time_nz = (min_reg != 7'd0) || (sec_reg != 6'd0);

    // Time arithmetic: add a step (saturating at 99:59), remove a step
    // (clamping at 00:00) and the one-second decrement.
    always_comb begin
        up_sum = {1'b0, sec_reg} + STEP7;
        if (up_sum >= 7'd60) begin
            if (min_reg >= 7'd99) begin
                up_min = 7'd99;
                up_sec = 6'd59;
            end else begin
                up_min = min_reg + 7'd1;
                up_sec = 6'(up_sum - 7'd60);
            end
        end else begin
            up_min = min_reg;
            up_sec = up_sum[5:0];
        end

        if (sec_reg < STEP6) begin
            if (min_reg == 7'd0) begin
                dn_min = 7'd0;
                dn_sec = 6'd0;
            end else begin
                dn_min = min_reg - 7'd1;
                dn_sec = 6'({1'b0, sec_reg} + 7'd60 - STEP7);
            end
        end else begin
            dn_min = min_reg;
            dn_sec = sec_reg - STEP6;
        end
        dn_zero = (dn_min == 7'd0) && (dn_sec == 6'd0);

        if (sec_reg == 6'd0) begin
            dec_min = min_reg - 7'd1;
            dec_sec = 6'd59;
        end else begin
            dec_min = min_reg;
            dec_sec = sec_reg - 6'd1;
        end
        dec_zero = (dec_min == 7'd0) && (dec_sec == 6'd0);
    end

    // Next-state, time, door and counter logic.
    always_comb begin
        state_next     = state_reg;
        min_next       = min_reg;
        sec_next       = sec_reg;
        door_next      = door_reg;
        done_next      = 1'b0;
        alarm_cnt_next = alarm_cnt_reg;
        presc_next     = '0;

        case (state_reg)
            ST_IDLE: begin
                if (ev_door) begin
                    door_next = ~door_reg;
                end else if (ev_up) begin
                    state_next = ST_SET;
                    min_next   = 7'd0;
                    sec_next   = STEP6;
                end
            end
            ST_SET, ST_PAUSE: begin
                if (ev_cancel) begin
                    state_next = ST_IDLE;
                    min_next   = 7'd0;
                    sec_next   = 6'd0;
                end else if (ev_door) begin
                    door_next = ~door_reg;
                end else if (ev_start) begin
                    if (time_nz && !door_reg) begin
                        state_next = ST_RUN;
                    end
                end else if (ev_up) begin
                    min_next = up_min;
                    sec_next = up_sec;
                end else if (ev_down) begin
                    min_next = dn_min;
                    sec_next = dn_sec;
                    if (dn_zero) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                // Cancel and Door beat the tick; the tick beats Up.
                if (ev_cancel) begin
                    state_next = ST_PAUSE;
                end else if (ev_door) begin
                    door_next  = ~door_reg;
                    state_next = ST_PAUSE;
                end else if (tick) begin
                    min_next = dec_min;
                    sec_next = dec_sec;
                    if (dec_zero) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end else if (ev_up) begin
                    min_next = up_min;
                    sec_next = up_sec;
                end
            end
            ST_DONE: begin
                if (|rise_button) begin
                    state_next = ST_IDLE;
                    if (ev_door) begin
                        door_next = ~door_reg;
                    end
                end else if (tick) begin
                    if (alarm_cnt_reg == ALARM_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        alarm_cnt_next = alarm_cnt_reg + ALARM_ONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                min_next   = 7'd0;
                sec_next   = 6'd0;
            end
        endcase

        // Prescaler restarts on every state entry and only runs in RUN/DONE.
        if (state_next != state_reg) begin
            presc_next     = '0;
            alarm_cnt_next = '0;
        end else if (tick) begin
            presc_next = '0;
        end else if ((state_reg == ST_RUN) || (state_reg == ST_DONE)) begin
            presc_next = presc_reg + PRESC_ONE;
        end else begin
            presc_next = '0;
        end
    end

    // State and output registers; heater/alarm follow the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            min_reg       <= 7'd0;
            sec_reg       <= 6'd0;
            door_reg      <= 1'b0;
            done_reg      <= 1'b0;
            heater_reg    <= 1'b0;
            alarm_reg     <= 1'b0;
            presc_reg     <= '0;
            alarm_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            min_reg       <= min_next;
            sec_reg       <= sec_next;
            door_reg      <= door_next;
            done_reg      <= done_next;
            heater_reg    <= (state_next == ST_RUN);
            alarm_reg     <= (state_next == ST_DONE);
            presc_reg     <= presc_next;
            alarm_cnt_reg <= alarm_cnt_next;
        end
    end

    assign min_out    = min_reg;
    assign sec_out    = sec_reg;
    assign state      = state_reg;
    assign heater_on  = heater_reg;
    assign door_open  = door_reg;
    assign alarm      = alarm_reg;
    assign done_pulse = done_reg;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl: directed scenarios followed by
// randomized button traffic, all checked against a total-seconds model.
module tb_cook_timer_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int STEP_SEC  = 10;
    localparam int ALARM_SEC = 3;
    localparam int MAX_TOTAL = 99 * 60 + 59;

    localparam logic [4:0] B_UP     = 5'b00001;
    localparam logic [4:0] B_DOOR   = 5'b00010;
    localparam logic [4:0] B_START  = 5'b00100;
    localparam logic [4:0] B_CANCEL = 5'b01000;
    localparam logic [4:0] B_DOWN   = 5'b10000;

    logic       clk;
    logic       reset;
    logic [4:0] rise_button;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic [2:0] state;
    logic       heater_on;
    logic       door_open;
    logic       alarm;
    logic       done_pulse;

    cook_timer_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .STEP_SEC (STEP_SEC),
        .ALARM_SEC(ALARM_SEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rise_button(rise_button),
        .min_out    (min_out),
        .sec_out    (sec_out),
        .state      (state),
        .heater_on  (heater_on),
        .door_open  (door_open),
        .alarm      (alarm),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: remaining time as plain seconds, state as an integer,
    // and cycles spent in the current state.
    int m_total;
    int m_state;
    int m_door;
    int m_age;
    int m_done;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_state = 0;
        m_door  = 0;
        m_age   = 0;
        m_done  = 0;
    endtask

    // Apply one cycle's worth of buttons to the model.
    task automatic model_step(input logic [4:0] b);
        int  nxt;
        bit  cancel, door, start, up, down, tick;
        nxt    = m_state;
        cancel = b[3];
        door   = b[1] && !b[3];
        start  = b[2] && !b[3] && !b[1];
        up     = b[0] && (b[3:1] == 3'b000);
        down   = b[4] && (b[3:0] == 4'b0000);
        tick   = (m_state == 2 || m_state == 4) && (((m_age + 1) % CLK_HZ) == 0);
        m_done = 0;
        case (m_state)
            0: begin
                if (door) m_door = 1 - m_door;
                else if (up) begin nxt = 1; m_total = STEP_SEC; end
            end
            1, 3: begin
                if (cancel) begin nxt = 0; m_total = 0; end
                else if (door) m_door = 1 - m_door;
                else if (start) begin
                    if (m_total != 0 && m_door == 0) nxt = 2;
                end else if (up) begin
                    m_total = (m_total + STEP_SEC > MAX_TOTAL) ? MAX_TOTAL : m_total + STEP_SEC;
                end else if (down) begin
                    m_total = (m_total < STEP_SEC) ? 0 : m_total - STEP_SEC;
                    if (m_total == 0) nxt = 0;
                end
            end
            2: begin
                if (cancel) nxt = 3;
                else if (door) begin m_door = 1 - m_door; nxt = 3; end
                else if (tick) begin
                    m_total = m_total - 1;
                    if (m_total == 0) begin nxt = 4; m_done = 1; end
                end else if (up) begin
                    m_total = (m_total + STEP_SEC > MAX_TOTAL) ? MAX_TOTAL : m_total + STEP_SEC;
                end
            end
            4: begin
                if (b != 5'b0) begin
                    nxt = 0;
                    if (door) m_door = 1 - m_door;
                end else if (m_age + 1 == ALARM_SEC * CLK_HZ) begin
                    nxt = 0;
                end
            end
            default: nxt = 0;
        endcase
        if (nxt != m_state) m_age = 0;
        else m_age = m_age + 1;
        m_state = nxt;
    endtask

    task automatic check_all();
        check("state",      int'(state),      m_state);
        check("min",        int'(min_out),    m_total / 60);
        check("sec",        int'(sec_out),    m_total % 60);
        check("heater_on",  int'(heater_on),  (m_state == 2) ? 1 : 0);
        check("alarm",      int'(alarm),      (m_state == 4) ? 1 : 0);
        check("door_open",  int'(door_open),  m_door);
        check("done_pulse", int'(done_pulse), m_done);
    endtask

    // One clock cycle: drive buttons, advance model, sample after the edge.
    task automatic cycle(input logic [4:0] b);
        rise_button = b;
        model_step(b);
        @(posedge clk);
        #1;
        if (b != 5'b0)
            $display("txn t=%0t btn=%b -> state=%0d %02d:%02d door=%0d heater=%0d",
                     $time, b, state, min_out, sec_out, door_open, heater_on);
        check_all();
        rise_button = 5'b0;
    endtask

    task automatic run_until_sec(input int target, input int budget);
        int n;
        n = 0;
        while (int'(sec_out) != target && n < budget) begin
            cycle(5'b0);
            n++;
        end
        check("wait_sec_timeout", int'(sec_out), target);
    endtask

    int done_cnt;
    int alarm_cycles;
    int n;

    initial begin
        reset       = 1'b0;
        rise_button = 5'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_time",  int'({min_out, sec_out}), 0);
        check("rst_flags", int'({heater_on, door_open, alarm, done_pulse}), 0);
        reset = 1'b1;

        // Up x3 -> SET 00:30, Start -> RUN, first decrement after 10 cycles.
        repeat (3) cycle(B_UP);
        check("set_state", int'(state), 1);
        check("set_sec",   int'(sec_out), 30);
        cycle(B_START);
        check("run_state", int'(state), 2);
        check("run_heater", int'(heater_on), 1);
        repeat (9) cycle(5'b0);
        check("pre_tick_sec", int'(sec_out), 30);
        cycle(5'b0);
        check("first_tick_sec", int'(sec_out), 29);

        // Cancel in RUN -> PAUSE, again -> IDLE with time cleared.
        cycle(B_CANCEL);
        check("cancel_pause", int'(state), 3);
        cycle(B_CANCEL);
        check("cancel_idle", int'(state), 0);
        check("cancel_clear", int'(sec_out), 0);

        // Run 00:10 to completion: one done_pulse, alarm for 30 cycles.
        cycle(B_UP);
        cycle(B_START);
        done_cnt = 0;
        n = 0;
        while (done_pulse !== 1'b1 && n < 200) begin
            cycle(5'b0);
            n++;
        end
        check("done_seen", int'(done_pulse), 1);
        check("done_state", int'(state), 4);
        done_cnt = 1;
        alarm_cycles = 1;
        n = 0;
        while (int'(state) != 0 && n < 100) begin
            cycle(5'b0);
            if (alarm === 1'b1) alarm_cycles++;
            if (done_pulse === 1'b1) done_cnt++;
            n++;
        end
        check("alarm_cycles", alarm_cycles, ALARM_SEC * CLK_HZ);
        check("done_once", done_cnt, 1);
        check("alarm_off", int'(alarm), 0);

        // Door interlock at 00:15.
        repeat (2) cycle(B_UP);
        cycle(B_START);
        run_until_sec(15, 100);
        cycle(B_DOOR);
        check("door_pause", int'(state), 3);
        check("door_heater", int'(heater_on), 0);
        check("door_flag", int'(door_open), 1);
        cycle(B_START);
        check("door_blocks_start", int'(state), 3);
        cycle(B_DOOR);
        cycle(B_START);
        check("resume_state", int'(state), 2);
        check("resume_sec", int'(sec_out), 15);
        cycle(B_CANCEL);
        cycle(B_CANCEL);

        // Down from 00:05 -> 00:00 and IDLE.
        cycle(B_UP);
        cycle(B_START);
        run_until_sec(5, 100);
        cycle(B_CANCEL);
        cycle(B_DOWN);
        check("down_idle", int'(state), 0);
        check("down_zero", int'(sec_out), 0);

        // Up at 00:55 -> 01:05, then saturate at 99:59.
        repeat (6) cycle(B_UP);
        cycle(B_START);
        run_until_sec(55, 100);
        cycle(B_CANCEL);
        cycle(B_UP);
        check("carry_min", int'(min_out), 1);
        check("carry_sec", int'(sec_out), 5);
        repeat (593) cycle(B_UP);
        check("near_max", int'(min_out) * 60 + int'(sec_out), 99 * 60 + 55);
        cycle(B_UP);
        check("sat_min", int'(min_out), 99);
        check("sat_sec", int'(sec_out), 59);
        cycle(B_CANCEL);

        // Cancel+Start+Up together from SET -> IDLE, cleared.
        cycle(B_UP);
        cycle(B_CANCEL | B_START | B_UP);
        check("combo_idle", int'(state), 0);
        check("combo_clear", int'(sec_out), 0);

        // Asynchronous reset in RUN at 00:10.
        cycle(B_UP);
        cycle(B_START);
        check("pre_reset_run", int'(state), 2);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        $display("txn t=%0t async reset asserted", $time);
        check("arst_state", int'(state), 0);
        check("arst_time",  int'({min_out, sec_out}), 0);
        check("arst_flags", int'({heater_on, door_open, alarm, done_pulse}), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [4:0] b;
            r = $urandom_range(0, 99);
            if (r < 4)       b = B_UP;
            else if (r < 6)  b = B_DOWN;
            else if (r < 8)  b = B_START;
            else if (r < 9)  b = B_DOOR;
            else if (r < 10) b = B_CANCEL;
            else if (r < 11) b = 5'($urandom_range(1, 31));
            else             b = 5'b0;
            cycle(b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
